// File: rtl/xmem_part_decoder_if.sv
// Request/decoded-output bundle for xmem_part_decoder.
// master = upstream request mux + downstream bank mux side, slave = the decoder.
`timescale 1ns/1ps
interface xmem_part_decoder_if #(
    parameter int PAW      = 16,
    parameter int PIW      = 3,
    parameter int CFG_ABIT = 19,
    parameter int DW       = 32
);
    // Handshake: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never waits on ready, and payload stays stable
    // while valid is high and ready is low.
    logic                req_valid;
    logic                req_ready;
    logic [CFG_ABIT:0]   req_addr;
    logic                req_we;
    logic [DW-1:0]       req_wdata;
    logic                out_valid;
    logic                out_ready;
    logic [PIW-1:0]      out_part;
    logic [PAW-1:0]      out_offset;
    logic                out_we;
    logic [DW-1:0]       out_wdata;
    logic                out_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, out_ready,
        input  req_ready, out_valid, out_part, out_offset, out_we, out_wdata, out_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, out_ready,
        output req_ready, out_valid, out_part, out_offset, out_we, out_wdata, out_err
    );
endinterface

// File: rtl/xmem_part_decoder.sv
// Address-partition decoder: range-start table plus 2-stage address -> (partition, offset) pipe.
// Optional XMEM_RANGE_CHECK_EN: misses and config reads produce an error beat instead of clamping.
`timescale 1ns/1ps
module xmem_part_decoder #(
    parameter int PART_NUM = 4,
    parameter int AW       = 18,
    parameter int PAW      = 16,
    parameter int PIW      = 3,
    parameter int CFG_ABIT = 19,
    parameter int DW       = 32
) (
    input  logic                clk,
    input  logic                rstn,
    xmem_part_decoder_if.slave  bus
);
    localparam int NE = PART_NUM + 1;
`ifdef XMEM_RANGE_CHECK_EN
    localparam logic [PIW-1:0] MISS_PART = '0;
`else
    localparam logic [PIW-1:0] MISS_PART = PIW'(PART_NUM - 1);
`endif

    logic [AW:0]     rs [NE];
    logic            stall;
    logic            accept;
    logic            is_cfg;
    logic            cfg_wr;
    logic [3:0]      cfg_idx;
    logic [AW:0]     addr_ext;
    logic            hit_found;
    logic [PIW-1:0]  hit_idx;
    logic [PIW-1:0]  sel_part;
    logic [PAW-1:0]  sel_base;
    logic            unused_bits;

    logic            s1_valid;
    logic [PIW-1:0]  s1_part;
    logic [PAW-1:0]  s1_base;
    logic [PAW-1:0]  s1_addr;
    logic            s1_we;
    logic [DW-1:0]   s1_wdata;
    logic            s1_miss;

    logic            out_valid_q;
    logic [PIW-1:0]  out_part_q;
    logic [PAW-1:0]  out_offset_q;
    logic            out_we_q;
    logic [DW-1:0]   out_wdata_q;
    logic            out_err_q;

    assign stall         = out_valid_q & ~bus.out_ready;
    assign bus.req_ready = ~stall;
    assign accept        = bus.req_valid & ~stall;
    assign is_cfg        = bus.req_addr[CFG_ABIT];
    assign cfg_idx       = bus.req_addr[3:0];
    assign cfg_wr        = accept & is_cfg & bus.req_we & (cfg_idx <= 4'(PART_NUM));
    assign addr_ext      = {1'b0, bus.req_addr[AW-1:0]};
    assign unused_bits   = ^{bus.req_addr[CFG_ABIT-1:AW], bus.req_wdata[DW-1:AW+1]};

    // Scan from the top down so the lowest matching partition wins on overlap.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = PART_NUM - 1; i >= 0; i--) begin
            if (addr_ext >= rs[i] && addr_ext < rs[i+1]) begin
                hit_found = 1'b1;
                hit_idx   = PIW'(i);
            end
        end
    end

    // Only the low PAW bits of base and address matter for the offset.
    always_comb begin
        sel_part = hit_found ? hit_idx : MISS_PART;
        sel_base = '0;
        for (int i = 0; i < PART_NUM; i++) begin
            if (sel_part == PIW'(i)) sel_base = rs[i][PAW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NE; i++) rs[i] <= (AW+1)'(i << PAW);
            s1_valid <= 1'b0;
            s1_part  <= '0;
            s1_base  <= '0;
            s1_addr  <= '0;
            s1_we    <= 1'b0;
            s1_wdata <= '0;
            s1_miss  <= 1'b0;
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (cfg_wr && cfg_idx == 4'(i)) rs[i] <= bus.req_wdata[AW:0];
            end
            if (!stall) begin
`ifdef XMEM_RANGE_CHECK_EN
                s1_valid <= accept & (~is_cfg | ~bus.req_we);
                s1_miss  <= is_cfg | ~hit_found;
`else
                s1_valid <= accept & ~is_cfg;
                s1_miss  <= 1'b0;
`endif
                s1_part  <= sel_part;
                s1_base  <= sel_base;
                s1_addr  <= bus.req_addr[PAW-1:0];
                s1_we    <= bus.req_we & ~is_cfg;
                s1_wdata <= bus.req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q  <= 1'b0;
            out_part_q   <= '0;
            out_offset_q <= '0;
            out_we_q     <= 1'b0;
            out_wdata_q  <= '0;
            out_err_q    <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_part_q   <= s1_miss ? '0 : s1_part;
                out_offset_q <= s1_miss ? '0 : (s1_addr - s1_base);
                out_we_q     <= s1_we & ~s1_miss;
                out_wdata_q  <= s1_wdata;
                out_err_q    <= s1_miss;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_part   = out_part_q;
    assign bus.out_offset = out_offset_q;
    assign bus.out_we     = out_we_q;
    assign bus.out_wdata  = out_wdata_q;
    assign bus.out_err    = out_err_q;
endmodule

// File: tb/tb_xmem_part_decoder.sv
// Bench for xmem_part_decoder: directed scenarios plus random traffic against a table model.
// Honours XMEM_RANGE_CHECK_EN the same way the design does.
`timescale 1ns/1ps
module tb_xmem_part_decoder;
    localparam int PART_NUM = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    xmem_part_decoder_if #(.PAW(16), .PIW(3), .CFG_ABIT(19), .DW(32)) pif ();

    xmem_part_decoder #(
        .PART_NUM(PART_NUM), .AW(18), .PAW(16), .PIW(3), .CFG_ABIT(19), .DW(32)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (pif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [52:0] exp_q[$];
    int rs_m[PART_NUM+1];
    bit rand_rdy = 0;
    logic        prev_stall = 0;
    logic [52:0] prev_beat;
    logic [2:0]  last_part;
    logic [15:0] last_off;
    logic        last_we;
    logic        last_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [52:0] pack(input int part, input int off, input logic we,
                                         input logic [31:0] d, input logic err);
        logic [2:0]  p = part[2:0];
        logic [15:0] o = off[15:0];
        return {p, o, we, d, err};
    endfunction

    function automatic void table_defaults();
        for (int i = 0; i <= PART_NUM; i++) rs_m[i] = i * 65536;
    endfunction

    // Reference: first partition whose [start, next start) range holds the address.
    function automatic logic [52:0] model_data(input int a, input logic we, input logic [31:0] d);
        int part = -1;
        for (int i = 0; i < PART_NUM; i++)
            if (part < 0 && rs_m[i] <= a && a < rs_m[i+1]) part = i;
        if (part >= 0) return pack(part, (a - rs_m[part]) & 'hFFFF, we, d, 1'b0);
`ifdef XMEM_RANGE_CHECK_EN
        return pack(0, 0, 1'b0, d, 1'b1);
`else
        return pack(PART_NUM - 1, (a - rs_m[PART_NUM-1]) & 'hFFFF, we, d, 1'b0);
`endif
    endfunction

    function automatic void model_accept();
        int idx;
        if (pif.req_addr[19]) begin
            if (pif.req_we) begin
                idx = int'(pif.req_addr[3:0]);
                if (idx <= PART_NUM) rs_m[idx] = int'(pif.req_wdata[18:0]);
            end
`ifdef XMEM_RANGE_CHECK_EN
            else exp_q.push_back(pack(0, 0, 1'b0, pif.req_wdata, 1'b1));
`endif
        end else begin
            exp_q.push_back(model_data(int'(pif.req_addr[17:0]), pif.req_we, pif.req_wdata));
        end
    endfunction

    // Scoreboard/monitor: samples on the falling edge, when everything is settled.
    always @(negedge clk) begin
        logic [52:0] cur, e;
        cur = {pif.out_part, pif.out_offset, pif.out_we, pif.out_wdata, pif.out_err};
        if (rstn) begin
            if (prev_stall) begin
                check("hold_valid", pif.out_valid, 1);
                check("hold_beat", cur, prev_beat);
            end
            if (pif.out_valid && pif.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("beat_part", pif.out_part, e[52:50]);
                    check("beat_offset", pif.out_offset, e[49:34]);
                    check("beat_we", pif.out_we, e[33]);
                    check("beat_wdata", pif.out_wdata, e[32:1]);
                    check("beat_err", pif.out_err, e[0]);
                    {last_part, last_off, last_we} = {pif.out_part, pif.out_offset, pif.out_we};
                    last_err = pif.out_err;
                end
            end
            prev_stall = pif.out_valid && !pif.out_ready;
            prev_beat  = cur;
            if (pif.req_valid && pif.req_ready) model_accept();
        end else begin
            prev_stall = 0;
        end
    end

    // All driver tasks start and end one time unit after a rising edge.
    task automatic send(input logic [19:0] a, input logic we, input logic [31:0] d);
        int  guard = 0;
        bit  done  = 0;
        pif.req_valid = 1'b1;
        pif.req_addr  = a;
        pif.req_we    = we;
        pif.req_wdata = d;
        while (!done) begin
            if (rand_rdy) pif.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            done = pif.req_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 60) begin
                check("accept_timeout", 0, 1);
                done = 1;
            end
        end
        pif.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rand_rdy) pif.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int g = 0;
        pif.out_ready = 1'b1;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        idle(2);
    endtask

    function automatic logic [19:0] cfg_addr(input int idx);
        logic [19:0] a = 20'h80000;
        a[3:0] = idx[3:0];
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int r;
        pif.req_valid = 1'b0;
        pif.req_addr  = '0;
        pif.req_we    = 1'b0;
        pif.req_wdata = '0;
        pif.out_ready = 1'b1;
        table_defaults();
        #1;
        check("rst_out_valid", pif.out_valid, 0);
        check("rst_out_part", pif.out_part, 0);
        check("rst_out_offset", pif.out_offset, 0);
        check("rst_out_we", pif.out_we, 0);
        check("rst_out_wdata", pif.out_wdata, 0);
        check("rst_out_err", pif.out_err, 0);
        check("rst_req_ready", pif.req_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(1);

        // Basic lookup with latency check.
        send(20'h12345, 1'b0, 32'hA5A5_0001);
        @(negedge clk);
        check("lat_n1_valid", pif.out_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", pif.out_valid, 1);
        @(posedge clk);
        #1;
        drain();
        check("t1_part", last_part, 1);
        check("t1_offset", last_off, 16'h2345);
        check("t1_err", last_err, 0);

        // Reprogram partition 1 start.
        send(cfg_addr(1), 1'b1, 32'h0000_8000);
        send(20'h09000, 1'b0, 32'h1);
        drain();
        check("t2_part", last_part, 1);
        check("t2_offset", last_off, 16'h1000);
        send(20'h07FFF, 1'b0, 32'h2);
        drain();
        check("t2b_part", last_part, 0);
        check("t2b_offset", last_off, 16'h7FFF);
        send(cfg_addr(1), 1'b1, 32'h0001_0000);

        // Back-to-back stream against a 3-cycle downstream stall.
        pif.out_ready = 1'b0;
        fork
            begin
                send(20'h00010, 1'b0, 32'h10);
                send(20'h10020, 1'b0, 32'h20);
                send(20'h20030, 1'b0, 32'h30);
                send(20'h30040, 1'b0, 32'h40);
            end
            begin
                repeat (2) @(posedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_req_ready", pif.req_ready, 0);
                end
                @(posedge clk);
                #1;
                pif.out_ready = 1'b1;
            end
        join
        drain();
        check("t3_last_part", last_part, 3);

        // Shrink the top partition so the address falls off the end.
        send(cfg_addr(4), 1'b1, 32'h0003_0000);
        send(20'h3FFFF, 1'b1, 32'hDEAD_BEEF);
        drain();
`ifdef XMEM_RANGE_CHECK_EN
        check("t4_err", last_err, 1);
        check("t4_part", last_part, 0);
        check("t4_offset", last_off, 0);
        check("t4_we", last_we, 0);
        send(cfg_addr(2), 1'b0, 32'h0);
        drain();
        check("t4_cfgrd_err", last_err, 1);
`else
        check("t4_part", last_part, 3);
        check("t4_offset", last_off, 16'hFFFF);
        check("t4_err", last_err, 0);
        check("t4_we", last_we, 1);
        send(cfg_addr(2), 1'b0, 32'h0);
        drain();
`endif
        send(cfg_addr(4), 1'b1, 32'h0004_0000);

        // In-flight lookup must use the table it was accepted against.
        send(20'h18000, 1'b0, 32'h5);
        send(cfg_addr(1), 1'b1, 32'h0001_8000);
        drain();
        check("t5_old_part", last_part, 1);
        check("t5_old_offset", last_off, 16'h8000);
        send(20'h18000, 1'b0, 32'h6);
        drain();
        check("t5_new_part", last_part, 1);
        check("t5_new_offset", last_off, 16'h0000);

        // Reset with two requests in flight.
        pif.out_ready = 1'b0;
        send(20'h01000, 1'b0, 32'h7);
        send(20'h02000, 1'b0, 32'h8);
        #1;
        rstn = 1'b0;
        #1;
        check("t6_async_valid", pif.out_valid, 0);
        exp_q.delete();
        table_defaults();
        pif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_quiet_valid", pif.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(20'h10000, 1'b0, 32'h9);
        drain();
        check("t6_table_part", last_part, 1);
        check("t6_table_offset", last_off, 0);

        // Random traffic with random downstream backpressure.
        rand_rdy = 1;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0)
                send(cfg_addr($urandom_range(0, 9)), 1'b1, {$urandom_range(0, 15), $urandom_range(0, 'h4FFFF)});
            else if (r == 1)
                send(cfg_addr(k % (PART_NUM + 1)), 1'b1, (k % (PART_NUM + 1)) * 65536);
            else if (r == 2)
                send(cfg_addr($urandom_range(0, 4)), 1'b0, $urandom);
            else
                send({2'b00, 18'($urandom_range(0, 'h3FFFF))}, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 0;
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
